// File: rtl/fetch_arbiter_pkg.sv
// Shared types and helpers for the instruction-fetch arbiter.
package fetch_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } fetch_state_e;

    localparam logic [7:0] COALESCE_MAX = 8'hFF;

    // Add up to 15 to an 8-bit counter, pinning at COALESCE_MAX instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0_0000, b};
        return s[8] ? COALESCE_MAX : s[7:0];
    endfunction

endpackage

// File: rtl/fetch_arbiter_rr_pick.sv
// Round-robin picker: first set bit of the eligible mask at or after the pointer, wrapping.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_grant
);

    logic [IDX_W:0] w_off;
    logic [IDX_W:0] w_best;

    // Distance from the pointer decides priority; smallest distance wins.
    always_comb begin
        o_found = 1'b0;
        o_grant = '0;
        w_off   = '0;
        w_best  = '0;
        for (int i = 0; i < N; i++) begin
            if ((IDX_W+1)'(i) >= {1'b0, i_ptr})
                w_off = (IDX_W+1)'(i) - {1'b0, i_ptr};
            else
                w_off = (IDX_W+1)'(i) + (IDX_W+1)'(N) - {1'b0, i_ptr};
            if (i_eligible[i] && (!o_found || (w_off < w_best))) begin
                o_found = 1'b1;
                w_best  = w_off;
                o_grant = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fetch_arbiter.sv
// Shares one program-memory read channel among several fetchers, round-robin,
// serving every waiting fetcher with the same address from a single access.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no access outstanding; pick next eligible fetcher
// ST_ISSUE | access to r_mem_addr outstanding; wait for mem_read_ready
module fetch_arbiter
    import fetch_arbiter_pkg::*;
#(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int NUM_REQUESTERS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] req_read_valid,
    input  logic [ADDR_BITS-1:0]      req_read_address [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] req_read_ready,
    output logic [DATA_BITS-1:0]      req_read_data    [NUM_REQUESTERS],
    output logic                      mem_read_valid,
    output logic [ADDR_BITS-1:0]      mem_read_address,
    input  logic                      mem_read_ready,
    input  logic [DATA_BITS-1:0]      mem_read_data,
    output logic [7:0]                coalesce_count
);

    localparam int IDX_W = $clog2(NUM_REQUESTERS);

    fetch_state_e              r_state;
    logic [IDX_W-1:0]          r_rr_ptr;
    logic [IDX_W-1:0]          r_grant;
    logic                      r_mem_valid;
    logic [ADDR_BITS-1:0]      r_mem_addr;
    logic [NUM_REQUESTERS-1:0] r_ready;
    logic [DATA_BITS-1:0]      r_data [NUM_REQUESTERS];
    logic [7:0]                r_coalesce;

    logic [NUM_REQUESTERS-1:0] w_eligible;
    logic [NUM_REQUESTERS-1:0] w_match;
    logic                      w_found;
    logic [IDX_W-1:0]          w_grant;
    logic [3:0]                w_coal_n;

    assign w_eligible = req_read_valid & ~r_ready;

    rr_pick #(
        .N     (NUM_REQUESTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_eligible (w_eligible),
        .i_ptr      (r_rr_ptr),
        .o_found    (w_found),
        .o_grant    (w_grant)
    );

    // A granted fetcher that dropped valid is no longer eligible, so it falls out here.
    always_comb begin
        w_match  = '0;
        w_coal_n = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            w_match[k] = w_eligible[k] && (req_read_address[k] == r_mem_addr);
            if (w_match[k] && (IDX_W'(k) != r_grant))
                w_coal_n = w_coal_n + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_ready     <= '0;
            r_coalesce  <= '0;
            for (int k = 0; k < NUM_REQUESTERS; k++)
                r_data[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REQUESTERS; k++) begin
                if (r_ready[k] && !req_read_valid[k])
                    r_ready[k] <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_grant;
                        r_mem_addr  <= req_read_address[w_grant];
                        r_mem_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_read_ready) begin
                        for (int k = 0; k < NUM_REQUESTERS; k++) begin
                            if (w_match[k]) begin
                                r_ready[k] <= 1'b1;
                                r_data[k]  <= mem_read_data;
                            end
                        end
                        r_coalesce  <= sat_add8(r_coalesce, w_coal_n);
                        r_mem_valid <= 1'b0;
                        r_rr_ptr    <= (r_grant == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : r_grant + 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_read_ready   = r_ready;
    assign req_read_data    = r_data;
    assign mem_read_valid   = r_mem_valid;
    assign mem_read_address = r_mem_addr;
    assign coalesce_count   = r_coalesce;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_read_valid;
    logic [7:0]  req_read_address [2];
    logic [1:0]  req_read_ready;
    logic [15:0] req_read_data    [2];
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [7:0]  coalesce_count;

    int n_cmp;
    int n_bad;

    logic [7:0] exp_rr [4] = '{8'h01, 8'h02, 8'h01, 8'h02};

    fetch_arbiter #(
        .ADDR_BITS      (8),
        .DATA_BITS      (16),
        .NUM_REQUESTERS (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_read_valid   (req_read_valid),
        .req_read_address (req_read_address),
        .req_read_ready   (req_read_ready),
        .req_read_data    (req_read_data),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .coalesce_count   (coalesce_count)
    );

    always #5 clk = ~clk;

    task automatic apply_reset;
        reset               = 1'b1;
        req_read_valid      = 2'b00;
        req_read_address[0] = 8'h00;
        req_read_address[1] = 8'h00;
        mem_read_ready      = 1'b0;
        mem_read_data       = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset               = 1'b1;
        req_read_valid      = 2'b01;
        req_read_address[0] = 8'h33;
        req_read_address[1] = 8'h00;
        mem_read_ready      = 1'b1;
        mem_read_data       = 16'hFFFF;
        repeat (2) @(negedge clk);
        n_cmp++; if (mem_read_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mem_valid: got %b expected 0", mem_read_valid); end
        n_cmp++; if (mem_read_address !== 8'h00) begin n_bad++; $display("FAIL reset_mem_addr: got %h expected 00", mem_read_address); end
        n_cmp++; if (req_read_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b expected 00", req_read_ready); end
        n_cmp++; if (req_read_data[0] !== 16'h0000) begin n_bad++; $display("FAIL reset_data0: got %h expected 0000", req_read_data[0]); end
        n_cmp++; if (req_read_data[1] !== 16'h0000) begin n_bad++; $display("FAIL reset_data1: got %h expected 0000", req_read_data[1]); end
        n_cmp++; if (coalesce_count !== 8'd0) begin n_bad++; $display("FAIL reset_coalesce: got %0d expected 0", coalesce_count); end
        reset          = 1'b0;
        req_read_valid = 2'b00;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
    endtask

    task automatic test_single;
        req_read_address[0] = 8'h10;
        req_read_valid      = 2'b01;
        @(negedge clk);
        n_cmp++; if (mem_read_valid !== 1'b1) begin n_bad++; $display("FAIL single_issue_valid: got %b expected 1", mem_read_valid); end
        n_cmp++; if (mem_read_address !== 8'h10) begin n_bad++; $display("FAIL single_issue_addr: got %h expected 10", mem_read_address); end
        n_cmp++; if (req_read_ready !== 2'b00) begin n_bad++; $display("FAIL single_early_ready: got %b expected 00", req_read_ready); end
        @(negedge clk);
        n_cmp++; if (mem_read_valid !== 1'b1) begin n_bad++; $display("FAIL single_hold_valid: got %b expected 1", mem_read_valid); end
        mem_read_data  = 16'hA5C3;
        mem_read_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_read_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b expected 01", req_read_ready); end
        n_cmp++; if (req_read_data[0] !== 16'hA5C3) begin n_bad++; $display("FAIL single_data: got %h expected a5c3", req_read_data[0]); end
        n_cmp++; if (mem_read_valid !== 1'b0) begin n_bad++; $display("FAIL single_mem_clear: got %b expected 0", mem_read_valid); end
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        @(negedge clk);
        n_cmp++; if (req_read_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready_hold: got %b expected 01", req_read_ready); end
        n_cmp++; if (req_read_data[0] !== 16'hA5C3) begin n_bad++; $display("FAIL single_data_hold: got %h expected a5c3", req_read_data[0]); end
        n_cmp++; if (mem_read_valid !== 1'b0) begin n_bad++; $display("FAIL single_no_regrant: got %b expected 0", mem_read_valid); end
        req_read_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (req_read_ready !== 2'b00) begin n_bad++; $display("FAIL single_ready_drop: got %b expected 00", req_read_ready); end
    endtask

    task automatic test_round_robin;
        logic [7:0] got [4];
        int seen;
        apply_reset();
        seen = 0;
        for (int i = 0; i < 4; i++) got[i] = 8'h00;
        req_read_address[0] = 8'h01;
        req_read_address[1] = 8'h02;
        for (int cyc = 0; cyc < 60 && seen < 4; cyc++) begin
            for (int k = 0; k < 2; k++) req_read_valid[k] = !req_read_ready[k];
            if (mem_read_valid && !mem_read_ready) begin
                got[seen]      = mem_read_address;
                seen++;
                mem_read_ready = 1'b1;
                mem_read_data  = {8'h00, mem_read_address};
            end else begin
                mem_read_ready = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 4) begin n_bad++; $display("FAIL rr_timeout: got %0d grants expected 4", seen); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== exp_rr[i]) begin n_bad++; $display("FAIL rr_order[%0d]: got %h expected %h", i, got[i], exp_rr[i]); end
        end
        mem_read_ready = 1'b0;
        req_read_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_coalesce;
        apply_reset();
        req_read_address[0] = 8'h20;
        req_read_address[1] = 8'h20;
        req_read_valid      = 2'b11;
        @(negedge clk);
        n_cmp++; if (mem_read_address !== 8'h20) begin n_bad++; $display("FAIL coal_addr: got %h expected 20", mem_read_address); end
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h1234;
        @(negedge clk);
        mem_read_ready = 1'b0;
        n_cmp++; if (req_read_ready !== 2'b11) begin n_bad++; $display("FAIL coal_ready: got %b expected 11", req_read_ready); end
        n_cmp++; if (req_read_data[0] !== 16'h1234) begin n_bad++; $display("FAIL coal_data0: got %h expected 1234", req_read_data[0]); end
        n_cmp++; if (req_read_data[1] !== 16'h1234) begin n_bad++; $display("FAIL coal_data1: got %h expected 1234", req_read_data[1]); end
        n_cmp++; if (coalesce_count !== 8'd1) begin n_bad++; $display("FAIL coal_count: got %0d expected 1", coalesce_count); end
        @(negedge clk);
        n_cmp++; if (mem_read_valid !== 1'b0) begin n_bad++; $display("FAIL coal_single_access: got %b expected 0", mem_read_valid); end
        req_read_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_abandon;
        apply_reset();
        req_read_address[0] = 8'h30;
        req_read_valid      = 2'b01;
        @(negedge clk);
        req_read_valid      = 2'b10;
        req_read_address[1] = 8'h30;
        @(negedge clk);
        n_cmp++; if (mem_read_valid !== 1'b1) begin n_bad++; $display("FAIL abandon_still_issued: got %b expected 1", mem_read_valid); end
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        @(negedge clk);
        mem_read_ready = 1'b0;
        n_cmp++; if (mem_read_valid !== 1'b0) begin n_bad++; $display("FAIL abandon_complete: got %b expected 0", mem_read_valid); end
        n_cmp++; if (req_read_ready !== 2'b10) begin n_bad++; $display("FAIL abandon_ready: got %b expected 10", req_read_ready); end
        n_cmp++; if (req_read_data[1] !== 16'hBEEF) begin n_bad++; $display("FAIL abandon_data1: got %h expected beef", req_read_data[1]); end
        n_cmp++; if (coalesce_count !== 8'd1) begin n_bad++; $display("FAIL abandon_count: got %0d expected 1", coalesce_count); end
        req_read_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_issue;
        apply_reset();
        req_read_address[0] = 8'h20;
        req_read_address[1] = 8'h20;
        req_read_valid      = 2'b11;
        @(negedge clk);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h7777;
        @(negedge clk);
        mem_read_ready = 1'b0;
        req_read_valid = 2'b00;
        @(negedge clk);
        req_read_address[0] = 8'h40;
        req_read_valid      = 2'b01;
        @(negedge clk);
        n_cmp++; if (mem_read_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_issue: got %b expected 1", mem_read_valid); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_read_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_mem_valid: got %b expected 0", mem_read_valid); end
        n_cmp++; if (mem_read_address !== 8'h00) begin n_bad++; $display("FAIL rmid_mem_addr: got %h expected 00", mem_read_address); end
        n_cmp++; if (req_read_ready !== 2'b00) begin n_bad++; $display("FAIL rmid_ready: got %b expected 00", req_read_ready); end
        n_cmp++; if (coalesce_count !== 8'd0) begin n_bad++; $display("FAIL rmid_count: got %0d expected 0", coalesce_count); end
        n_cmp++; if (req_read_data[1] !== 16'h0000) begin n_bad++; $display("FAIL rmid_data1: got %h expected 0000", req_read_data[1]); end
        reset          = 1'b0;
        req_read_valid = 2'b00;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        @(negedge clk);
        mem_read_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_read_ready !== 2'b00) begin n_bad++; $display("FAIL rmid_late_ready: got %b expected 00", req_read_ready); end
        n_cmp++; if (req_read_data[0] !== 16'h0000) begin n_bad++; $display("FAIL rmid_late_data0: got %h expected 0000", req_read_data[0]); end
        n_cmp++; if (mem_read_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_late_valid: got %b expected 0", mem_read_valid); end
    endtask

    task automatic test_saturation;
        apply_reset();
        req_read_address[0] = 8'h50;
        req_read_address[1] = 8'h50;
        for (int i = 0; i < 300; i++) begin
            req_read_valid = 2'b11;
            @(negedge clk);
            mem_read_ready = 1'b1;
            mem_read_data  = 16'(i);
            @(negedge clk);
            if (i == 253) begin
                n_cmp++; if (coalesce_count !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d expected 254", coalesce_count); end
            end
            if (i == 254) begin
                n_cmp++; if (coalesce_count !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d expected 255", coalesce_count); end
            end
            if (i == 299) begin
                n_cmp++; if (coalesce_count !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d expected 255", coalesce_count); end
                n_cmp++; if (req_read_data[1] !== 16'd299) begin n_bad++; $display("FAIL sat_last_data: got %0d expected 299", req_read_data[1]); end
            end
            mem_read_ready = 1'b0;
            req_read_valid = 2'b00;
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp               = 0;
        n_bad               = 0;
        reset               = 1'b1;
        req_read_valid      = 2'b00;
        req_read_address[0] = 8'h00;
        req_read_address[1] = 8'h00;
        mem_read_ready      = 1'b0;
        mem_read_data       = 16'h0000;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_coalesce();
        test_abandon();
        test_reset_mid_issue();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_arbiter.md
FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8: program memory address width.
REQ-002 The block SHALL have parameter DATA_BITS, default 16: instruction width.
REQ-003 The block SHALL have parameter NUM_REQUESTERS, default 2: fetchers sharing one memory channel, with a legal range of 2..8.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_read_valid, input, [NUM_REQUESTERS-1:0]: per-fetcher request, held until that fetcher sees ready.
REQ-007 The block SHALL have port req_read_address, input, [ADDR_BITS-1:0] x NUM_REQUESTERS (unpacked): per-fetcher address.
REQ-008 The block SHALL have port req_read_ready, output, [NUM_REQUESTERS-1:0]: per-fetcher completion.
REQ-009 The block SHALL have port req_read_data, output, [DATA_BITS-1:0] x NUM_REQUESTERS (unpacked): per-fetcher instruction.
REQ-010 The block SHALL have port mem_read_valid, output, 1 bit: memory request.
REQ-011 The block SHALL have port mem_read_address, output, [ADDR_BITS-1:0]: memory address.
REQ-012 The block SHALL have port mem_read_ready, input, 1 bit: memory completion.
REQ-013 The block SHALL have port mem_read_data, input, [DATA_BITS-1:0]: memory data.
REQ-014 The block SHALL have port coalesce_count, output, 8 bits: saturating count of fetchers served without their own memory access.

Function
REQ-015 The block SHALL implement FSM states IDLE and ISSUE only.
REQ-016 A fetcher SHALL be eligible when its valid=1 and its ready=0.
REQ-017 In IDLE, when any fetcher is eligible, the block SHALL grant the first eligible index at or after rr_ptr (wrapping), register its address onto mem_read_address, set mem_read_valid=1 and enter ISSUE at the next edge.
REQ-018 In IDLE with no eligible fetcher, mem_read_valid SHALL stay 0.
REQ-019 In ISSUE, mem_read_valid and mem_read_address SHALL be held stable until mem_read_ready=1.
REQ-020 On the cycle mem_read_ready=1 in ISSUE, the block SHALL serve at the next edge every eligible fetcher whose address equals the granted address: req_read_data[k] <= mem_read_data, req_read_ready[k] <= 1.
REQ-021 On that same cycle, the block SHALL clear mem_read_valid, set rr_ptr = (grant+1) mod NUM_REQUESTERS and return to IDLE.
REQ-022 If the granted fetcher dropped valid before completion, the memory access SHALL still complete; the granted fetcher SHALL not be served, and matching others SHALL still be served.
REQ-023 coalesce_count SHALL increase by the number of served fetchers other than the granted one, saturating at 255.
REQ-024 req_read_ready[k] SHALL hold at 1, and req_read_data[k] SHALL hold stable, until req_read_valid[k]=0; ready SHALL then clear at the next edge.
REQ-025 A fetcher with ready=1 SHALL never be granted or coalesced.
REQ-026 Latency SHALL be: valid seen in IDLE at cycle t gives mem_read_valid=1 at t+1; mem_read_ready at cycle r gives req_read_ready=1 at r+1.
REQ-027 With zero-wait memory, back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-028 mem_read_ready asserted while in IDLE SHALL be ignored.

Reset
REQ-029 Reset SHALL force state=IDLE, mem_read_valid=0, mem_read_address=0, all req_read_ready=0, all req_read_data=0, rr_ptr=0 and coalesce_count=0 at the next edge, including mid-ISSUE.
REQ-030 A memory response pending when reset is applied SHALL be discarded.

Structure
REQ-031 The FSM state enum (IDLE, ISSUE) SHALL reside in a shared package with the other controller state types.
REQ-032 One combinational sub-module, rr_pick, SHALL take an eligible mask and rr_ptr and return the found flag and grant index; the arbiter SHALL instantiate it once.
REQ-033 No other sub-modules SHALL be used.

Verification
REQ-034 The bench SHALL cover a single request: fetcher0 valid, addr 0x10, memory ready two cycles after valid with data 0xA5C3 -> mem_read_valid at t+1 with addr 0x10; req_read_ready[0]=1 and data 0xA5C3 one cycle after memory ready; ready clears the cycle after valid drops.
REQ-035 The bench SHALL cover round-robin: both fetchers continuously re-requesting distinct addresses 0x01 and 0x02 from reset -> memory sees addresses in order 0x01, 0x02, 0x01, 0x02.
REQ-036 The bench SHALL cover coalescing: both fetchers request addr 0x20 in the same cycle -> exactly one memory access; both readies rise together with identical data; coalesce_count=1.
REQ-037 The bench SHALL cover an abandoned request: fetcher0 drops valid mid-ISSUE while fetcher1 requests the same address -> memory access completes, only fetcher1 is served, coalesce_count=1.
REQ-038 The bench SHALL cover reset mid-ISSUE: reset asserted before mem_read_ready -> next edge gives mem_read_valid=0, all readies 0 and coalesce_count=0; a later mem_read_ready is ignored.
REQ-039 The bench SHALL cover saturation: 300 coalesced pairs -> coalesce_count=255.
